// File: rtl/pc_sequencer.sv
// pc_sequencer: two-phase FETCH/EXEC program counter sequencer for a ROM-driven machine.
// Optional macro HALT_DETECT_EN: an EXEC whose next address equals pc retires, then halts.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        flags_we,
  input  logic [3:0]  alu_nzvc,
  input  logic [7:0]  rom_addr,
  output logic [7:0]  rom_pc,
  output logic [3:0]  rom_nzvc,
  output logic [7:0]  pc,
  output logic [1:0]  state,
  output logic        step_done,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] cnt_q, cnt_d;
  logic        halt_hit;

`ifdef HALT_DETECT_EN
  // A self-referencing next address means the program has parked itself.
  assign halt_hit = (rom_addr == pc_q);
`else
  assign halt_hit = 1'b0;
`endif

  // Next-state, datapath update and retire pulse.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    step_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d      = rom_addr;
        cnt_d     = cnt_q + 16'd1;
        step_done = ~reset;
        if (flags_we)
          flags_d = alu_nzvc;
        if (halt_hit)
          state_d = S_HALT;
        else if (run)
          state_d = S_FETCH;
        else
          state_d = S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      flags_q <= 4'h0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_pc     = pc_q;
  assign rom_nzvc   = flags_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized bench for pc_sequencer against a behavioural model.
// Model follows the retire/flag/halt rules directly, one call per clock.
module tb_pc_sequencer;

  localparam logic [7:0] RPC = 8'h80;
`ifdef HALT_DETECT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        flags_we = 1'b0;
  logic [3:0]  alu_nzvc = 4'h0;
  logic [7:0]  rom_addr = 8'h00;
  logic [7:0]  rom_pc;
  logic [3:0]  rom_nzvc;
  logic [7:0]  pc;
  logic [1:0]  state;
  logic        step_done;
  logic [15:0] step_count;

  int vectors = 0;
  int errors  = 0;

  int          m_st = 0;
  logic [7:0]  m_pc = RPC;
  logic [3:0]  m_fl = 4'h0;
  logic [15:0] m_cnt = 16'h0;

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .flags_we  (flags_we),
    .alu_nzvc  (alu_nzvc),
    .rom_addr  (rom_addr),
    .rom_pc    (rom_pc),
    .rom_nzvc  (rom_nzvc),
    .pc        (pc),
    .state     (state),
    .step_done (step_done),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, land 1ns past the edge.
  task automatic apply(input logic r, input logic rn, input logic we,
                       input logic [3:0] alu, input logic [7:0] ra);
    reset    = r;
    run      = rn;
    flags_we = we;
    alu_nzvc = alu;
    rom_addr = ra;
    if (r) begin
      m_st  = 0;
      m_pc  = RPC;
      m_fl  = 4'h0;
      m_cnt = 16'h0;
    end else begin
      case (m_st)
        0: if (rn) m_st = 1;
        1: m_st = 2;
        2: begin
          if (we) m_fl = alu;
          m_cnt = m_cnt + 16'd1;
          if (HALT_ON && ra == m_pc) m_st = 3;
          else m_st = rn ? 1 : 0;
          m_pc = ra;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] exp_vec();
    logic sd;
    sd = (m_st == 2) && !reset;
    return {m_st[1:0], m_pc, m_pc, m_fl, m_cnt, sd};
  endfunction

  function automatic logic [38:0] act_vec();
    return {state, pc, rom_pc, rom_nzvc, step_count, step_done};
  endfunction

  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b1, 4'hF, 8'h33);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset0: got %h exp %h", act_vec(), exp_vec());
    end
    apply(1'b1, 1'b0, 1'b1, 4'hA, 8'h44);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset1: got %h exp %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_sequence();
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0, m_pc + 8'd1);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sequence c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (step_count !== 16'd3 || pc !== RPC + 8'd3) begin
      errors++;
      $display("FAIL seq_count: got cnt=%h pc=%h exp cnt=0003 pc=%h",
               step_count, pc, RPC + 8'd3);
    end
  endtask

  task automatic test_flags();
    logic [3:0] a;
    logic       done_0100;
    done_0100 = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      a = 4'($urandom);
      if (m_st == 2 && !done_0100) begin
        a = 4'b0100;
        done_0100 = 1'b1;
      end
      apply(1'b0, 1'b1, (i < 8) ? 1'b1 : 1'($urandom), a, 8'($urandom));
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL flags c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_run_drop();
    int n;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    n = 0;
    while (!(m_pc == 8'h05 && m_st == 1) && n < 10) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0, 8'h05);
      n++;
    end
    vectors++;
    if (n >= 10) begin
      errors++;
      $display("FAIL run_drop_reach: got timeout exp FETCH at pc 05");
    end
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 1'b0, 4'h0, 8'h5A);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run_drop c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    n = 0;
    while (!(m_pc == 8'hFF && m_st == 1) && n < 10) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0, 8'hFF);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pc_wrap c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, i < 2, 1'b0, 4'h0, 8'h01);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cnt_wrap c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_self_loop();
    int n;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    n = 0;
    while (!(m_pc == 8'h20 && m_st == 1) && n < 10) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0, 8'h20);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b1, 1'b1, 4'($urandom), 8'h20);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL self_loop c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    apply(1'b1, 1'b1, 1'b0, 4'h0, 8'h20);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL self_loop_exit: got %h exp %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    n = 0;
    while (m_st != 2 && n < 10) begin
      apply(1'b0, 1'b1, 1'b1, 4'hF, 8'h11 + 8'(n));
      n++;
    end
    apply(1'b1, 1'b1, 1'b1, 4'hF, 8'h77);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid: got %h exp %h", act_vec(), exp_vec());
    end
    apply(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    vectors++;
    if (pc !== RPC || state !== 2'd0 || step_done !== 1'b0 ||
        step_count !== 16'h0 || rom_nzvc !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: got pc=%h st=%0d sd=%b cnt=%h fl=%h",
               pc, state, step_done, step_count, rom_nzvc);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    apply(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(7) == 0) ? m_pc : 8'($urandom);
      apply($urandom_range(31) == 0, $urandom_range(3) != 0,
            1'($urandom), 4'($urandom), ra);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_flags();
    test_run_drop();
    test_wrap();
    test_self_loop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
